// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
//
// Coprocessor-0 register file plus the precise exception / interrupt / ERET
// commit point of the pipeline. It sits beside the MEM stage. It takes the
// exception, delay-slot, ERET and MTC0/MFC0 fields that the EX/MEM pipeline
// register hands over. From those it produces the pipeline-wide flush and the
// redirect PC.
//
// Registers implemented (address = {rd, sel}):
//   8'h40 BadVAddr  8'h48 Count  8'h58 Compare
//   8'h60 Status    8'h68 Cause  8'h70 EPC
// Any other address reads 0 and ignores writes.
//
// Ports
//   clk             clock
//   rst             asynchronous, active-low reset
//   ext_int[5:0]    level interrupt lines, already synchronous to clk
//   MEM_Valid       MEM holds a real instruction (bubbles never commit)
//   MEM_Exception   exception flagged for the MEM instruction
//   MEM_ExcCode     its exception code
//   MEM_isBD        MEM instruction is in a branch delay slot
//   MEM_PC          MEM instruction PC
//   badvaddr        faulting address (captured on AdEL/AdES)
//   MEM_eret_flush  MEM instruction is ERET
//   MEM_CP0WrEn     MTC0 in MEM
//   MEM_CP0Rd       MFC0 in MEM
//   MEM_CP0Addr     {rd[4:0], sel[2:0]}
//   MEM_GPR_RT      MTC0 write data
//   CP0Out          MFC0 read data (combinational, pre-edge value)
//   Exc_Flush       flush IF/ID/EX/MEM and PC this cycle
//   Exc_PC          redirect target while Exc_Flush=1
//   EPC_Out         current EPC
//   Int_Pending     an enabled interrupt is pending
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    input  logic        MEM_Valid,
    input  logic        MEM_Exception,
    input  logic [4:0]  MEM_ExcCode,
    input  logic        MEM_isBD,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] badvaddr,
    input  logic        MEM_eret_flush,
    input  logic        MEM_CP0WrEn,
    input  logic        MEM_CP0Rd,
    input  logic [7:0]  MEM_CP0Addr,
    input  logic [31:0] MEM_GPR_RT,
    output logic [31:0] CP0Out,
    output logic        Exc_Flush,
    output logic [31:0] Exc_PC,
    output logic [31:0] EPC_Out,
    output logic        Int_Pending
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;

    // ------------------------------------------------------------------
    // Architectural state. Status and Cause are kept as their writable or
    // updatable fields only. Constant bits are stitched in on read.
    // ------------------------------------------------------------------
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] count_reg,    count_next;
    logic [31:0] compare_reg,  compare_next;
    logic [31:0] epc_reg,      epc_next;
    logic [7:0]  status_im_reg,  status_im_next;
    logic        status_exl_reg, status_exl_next;
    logic        status_ie_reg,  status_ie_next;
    logic        cause_bd_reg,   cause_bd_next;
    logic        cause_ti_reg,   cause_ti_next;
    logic [1:0]  cause_ipsw_reg, cause_ipsw_next;
    logic [4:0]  cause_code_reg, cause_code_next;
    logic        tick_reg,       tick_next;

    // ------------------------------------------------------------------
    // Interrupt pending bits. IP[15:10] follow the hardware lines live.
    // The timer interrupt shares IP7 with ext_int[5].
    // ------------------------------------------------------------------
    logic [5:0] ip_hw;
    logic [7:0] ip_all;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_ip_hw
            assign ip_hw[gi] = ext_int[gi];
        end
    endgenerate
    assign ip_hw[5] = ext_int[5] | cause_ti_reg;
    assign ip_all   = {ip_hw, cause_ipsw_reg};

    logic int_pending;
    assign int_pending = status_ie_reg & ~status_exl_reg & (|(ip_all & status_im_reg));
    assign Int_Pending = int_pending;

    // Read views of Status and Cause. BEV (bit 22) is hard-wired to 1.
    logic [31:0] status_val;
    logic [31:0] cause_val;
    assign status_val = {9'd0, 1'b1, 6'd0, status_im_reg, 6'd0, status_exl_reg, status_ie_reg};
    assign cause_val  = {cause_bd_reg, cause_ti_reg, 14'd0, ip_all, 1'b0, cause_code_reg, 2'b00};

    // ------------------------------------------------------------------
    // Commit arbitration. The priority order is interrupt, then exception,
    // then ERET, then MTC0. Each winner masks everything below it, so only
    // one take_* can be high. Nothing commits while reset is asserted.
    // This keeps the flush low during reset even if MEM still shows an
    // instruction.
    // ------------------------------------------------------------------
    logic commit_ok;
    logic take_int, take_exc, take_trap, take_eret, take_mtc0;
    logic [4:0] trap_code;

    assign commit_ok = rst & MEM_Valid;
    assign take_int  = commit_ok & int_pending;
    assign take_exc  = commit_ok & ~int_pending & MEM_Exception;
    assign take_trap = take_int | take_exc;
    assign take_eret = commit_ok & ~int_pending & ~MEM_Exception & MEM_eret_flush;
    assign take_mtc0 = commit_ok & ~int_pending & ~MEM_Exception & ~MEM_eret_flush & MEM_CP0WrEn;
    assign trap_code = take_int ? CODE_INT : MEM_ExcCode;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    assign wr_count   = take_mtc0 & (MEM_CP0Addr == ADDR_COUNT);
    assign wr_compare = take_mtc0 & (MEM_CP0Addr == ADDR_COMPARE);
    assign wr_status  = take_mtc0 & (MEM_CP0Addr == ADDR_STATUS);
    assign wr_cause   = take_mtc0 & (MEM_CP0Addr == ADDR_CAUSE);
    assign wr_epc     = take_mtc0 & (MEM_CP0Addr == ADDR_EPC);

    assign Exc_Flush = take_trap | take_eret;
    assign Exc_PC    = take_eret ? epc_reg : EXC_VECTOR;
    assign EPC_Out   = epc_reg;

    // ------------------------------------------------------------------
    // MFC0 read mux. It returns the current (pre-edge) register contents.
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        unique case (MEM_CP0Addr)
            ADDR_BADVADDR: rd_data = badvaddr_reg;
            ADDR_COUNT:    rd_data = count_reg;
            ADDR_COMPARE:  rd_data = compare_reg;
            ADDR_STATUS:   rd_data = status_val;
            ADDR_CAUSE:    rd_data = cause_val;
            ADDR_EPC:      rd_data = epc_reg;
            default:       rd_data = 32'd0;
        endcase
    end

    assign CP0Out = (rst & MEM_CP0Rd) ? rd_data : 32'd0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        badvaddr_next   = badvaddr_reg;
        count_next      = count_reg;
        compare_next    = compare_reg;
        epc_next        = epc_reg;
        status_im_next  = status_im_reg;
        status_exl_next = status_exl_reg;
        status_ie_next  = status_ie_reg;
        cause_bd_next   = cause_bd_reg;
        cause_ti_next   = cause_ti_reg;
        cause_ipsw_next = cause_ipsw_reg;
        cause_code_next = cause_code_reg;
        tick_next       = ~tick_reg;

        // Count advances on every other edge. A software write takes
        // precedence and restarts the divide-by-two phase.
        if (wr_count) begin
            count_next = MEM_GPR_RT;
            tick_next  = 1'b0;
        end else begin
            count_next = count_reg + {31'd0, tick_reg};
        end

        // The timer interrupt is sticky. Writing Compare clears it, and
        // that clear beats a match on the same edge.
        if (wr_compare) begin
            compare_next  = MEM_GPR_RT;
            cause_ti_next = 1'b0;
        end else if (count_reg == compare_reg) begin
            cause_ti_next = 1'b1;
        end

        if (take_trap) begin
            cause_code_next = trap_code;
            status_exl_next = 1'b1;
            // A nested trap (EXL already set) keeps the original return
            // point so the outer handler can still ERET correctly.
            if (!status_exl_reg) begin
                epc_next      = MEM_isBD ? (MEM_PC - 32'd4) : MEM_PC;
                cause_bd_next = MEM_isBD;
            end
            if ((trap_code == CODE_ADEL) || (trap_code == CODE_ADES)) begin
                badvaddr_next = badvaddr;
            end
        end else if (take_eret) begin
            status_exl_next = 1'b0;
        end

        // BadVAddr has no software-writable bits, so it gets no write port.
        if (wr_status) begin
            status_im_next  = MEM_GPR_RT[15:8];
            status_exl_next = MEM_GPR_RT[1];
            status_ie_next  = MEM_GPR_RT[0];
        end
        if (wr_cause) begin
            cause_ipsw_next = MEM_GPR_RT[9:8];
        end
        if (wr_epc) begin
            epc_next = MEM_GPR_RT;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_reg   <= 32'd0;
            count_reg      <= 32'd0;
            compare_reg    <= 32'd0;
            epc_reg        <= 32'd0;
            status_im_reg  <= STATUS_RST[15:8];
            status_exl_reg <= STATUS_RST[1];
            status_ie_reg  <= STATUS_RST[0];
            cause_bd_reg   <= 1'b0;
            cause_ti_reg   <= 1'b0;
            cause_ipsw_reg <= 2'b00;
            cause_code_reg <= 5'd0;
            tick_reg       <= 1'b0;
        end else begin
            badvaddr_reg   <= badvaddr_next;
            count_reg      <= count_next;
            compare_reg    <= compare_next;
            epc_reg        <= epc_next;
            status_im_reg  <= status_im_next;
            status_exl_reg <= status_exl_next;
            status_ie_reg  <= status_ie_next;
            cause_bd_reg   <= cause_bd_next;
            cause_ti_reg   <= cause_ti_next;
            cause_ipsw_reg <= cause_ipsw_next;
            cause_code_reg <= cause_code_next;
            tick_reg       <= tick_next;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_unit
//
// Directed bench for cp0_exc_unit. Inputs change 1 ns after a rising edge.
// Combinational outputs are checked within that same cycle. Register contents
// are read back through MFC0 after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC = 32'hbfc0_0380;

    logic        clk;
    logic        rst;
    logic [5:0]  ext_int;
    logic        MEM_Valid;
    logic        MEM_Exception;
    logic [4:0]  MEM_ExcCode;
    logic        MEM_isBD;
    logic [31:0] MEM_PC;
    logic [31:0] badvaddr;
    logic        MEM_eret_flush;
    logic        MEM_CP0WrEn;
    logic        MEM_CP0Rd;
    logic [7:0]  MEM_CP0Addr;
    logic [31:0] MEM_GPR_RT;
    logic [31:0] CP0Out;
    logic        Exc_Flush;
    logic [31:0] Exc_PC;
    logic [31:0] EPC_Out;
    logic        Int_Pending;

    int total;
    int bad;
    logic mon_en;
    logic flush_seen = 1'b0;

    cp0_exc_unit #(
        .EXC_VECTOR (32'hbfc0_0380),
        .STATUS_RST (32'h0040_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_int        (ext_int),
        .MEM_Valid      (MEM_Valid),
        .MEM_Exception  (MEM_Exception),
        .MEM_ExcCode    (MEM_ExcCode),
        .MEM_isBD       (MEM_isBD),
        .MEM_PC         (MEM_PC),
        .badvaddr       (badvaddr),
        .MEM_eret_flush (MEM_eret_flush),
        .MEM_CP0WrEn    (MEM_CP0WrEn),
        .MEM_CP0Rd      (MEM_CP0Rd),
        .MEM_CP0Addr    (MEM_CP0Addr),
        .MEM_GPR_RT     (MEM_GPR_RT),
        .CP0Out         (CP0Out),
        .Exc_Flush      (Exc_Flush),
        .Exc_PC         (Exc_PC),
        .EPC_Out        (EPC_Out),
        .Int_Pending    (Int_Pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Catches any flush pulse during the idle window after reset.
    always @(negedge clk) begin
        if (mon_en && (Exc_Flush !== 1'b0)) flush_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_in();
        MEM_Valid      = 1'b0;
        MEM_Exception  = 1'b0;
        MEM_ExcCode    = 5'd0;
        MEM_isBD       = 1'b0;
        MEM_PC         = 32'd0;
        badvaddr       = 32'd0;
        MEM_eret_flush = 1'b0;
        MEM_CP0WrEn    = 1'b0;
        MEM_CP0Rd      = 1'b0;
        MEM_CP0Addr    = 8'd0;
        MEM_GPR_RT     = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        MEM_CP0Rd   = 1'b1;
        MEM_CP0Addr = addr;
        #1;
        chk(tag, CP0Out, exp);
        MEM_CP0Rd   = 1'b0;
        MEM_CP0Addr = 8'd0;
    endtask

    // One MTC0 instruction. The write itself must never raise a flush.
    task automatic mtc0(input string tag, input logic [7:0] addr, input logic [31:0] data);
        MEM_Valid   = 1'b1;
        MEM_CP0WrEn = 1'b1;
        MEM_CP0Addr = addr;
        MEM_GPR_RT  = data;
        #1;
        chk(tag, {31'd0, Exc_Flush}, 32'd0);
        tick();
        idle_in();
    endtask

    task automatic exc_step(input logic [4:0] code, input logic [31:0] pc,
                            input logic isbd, input logic [31:0] bva);
        MEM_Valid     = 1'b1;
        MEM_Exception = 1'b1;
        MEM_ExcCode   = code;
        MEM_PC        = pc;
        MEM_isBD      = isbd;
        badvaddr      = bva;
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst    = 1'b0;
        ext_int = 6'd0;
        idle_in();

        // ---- reset state ----
        MEM_CP0Rd   = 1'b1;
        MEM_CP0Addr = 8'h60;
        #2;
        chk("rst_cp0out", CP0Out, 32'd0);
        chk("rst_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("rst_intpend", {31'd0, Int_Pending}, 32'd0);
        chk("rst_epc_out", EPC_Out, 32'd0);
        chk("rst_exc_pc", Exc_PC, VEC);
        idle_in();
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // ---- 10 idle cycles: Count ticks every other edge ----
        repeat (10) tick();
        mon_en = 1'b0;
        chk("idle_flush", {31'd0, flush_seen}, 32'd0);
        rd_chk("idle_status", 8'h60, 32'h0040_0000);
        rd_chk("idle_count", 8'h48, 32'd5);

        // ---- Compare <- all ones clears the TI set by the 0==0 match ----
        mtc0("mtc0_cmp_fl", 8'h58, 32'hffff_ffff);
        rd_chk("cause_ti_clr", 8'h68, 32'd0);
        rd_chk("count_no_inc", 8'h48, 32'd5);
        rd_chk("compare_rd", 8'h58, 32'hffff_ffff);

        // ---- AdES in a delay slot ----
        exc_step(5'd5, 32'hbfc0_1004, 1'b1, 32'h8000_0003);
        chk("ades_flush", {31'd0, Exc_Flush}, 32'd1);
        chk("ades_pc", Exc_PC, VEC);
        tick();
        idle_in();
        #1;
        chk("ades_pulse", {31'd0, Exc_Flush}, 32'd0);
        chk("ades_epc_out", EPC_Out, 32'hbfc0_1000);
        rd_chk("ades_epc_rd", 8'h70, 32'hbfc0_1000);
        rd_chk("ades_cause", 8'h68, 32'h8000_0014);
        rd_chk("ades_bva", 8'h40, 32'h8000_0003);
        rd_chk("ades_status", 8'h60, 32'h0040_0002);

        // ---- nested exception with EXL=1: EPC/BD/BadVAddr kept ----
        exc_step(5'd12, 32'h0000_1234, 1'b0, 32'h1111_1111);
        chk("nest_flush", {31'd0, Exc_Flush}, 32'd1);
        tick();
        idle_in();
        chk("nest_epc", EPC_Out, 32'hbfc0_1000);
        rd_chk("nest_cause", 8'h68, 32'h8000_0030);
        rd_chk("nest_bva", 8'h40, 32'h8000_0003);

        // ---- MTC0 EPC then ERET ----
        mtc0("mtc0_epc_fl", 8'h70, 32'hbfc0_2000);
        MEM_Valid      = 1'b1;
        MEM_eret_flush = 1'b1;
        #1;
        chk("eret_flush", {31'd0, Exc_Flush}, 32'd1);
        chk("eret_pc", Exc_PC, 32'hbfc0_2000);
        tick();
        idle_in();
        rd_chk("eret_status", 8'h60, 32'h0040_0000);

        // ---- timer: Count<-0, Compare<-3, TI lands on the 6th edge after ----
        mtc0("mtc0_cnt_fl", 8'h48, 32'd0);
        mtc0("mtc0_cmp3_fl", 8'h58, 32'd3);
        repeat (5) tick();
        rd_chk("ti_not_yet", 8'h68, 32'h8000_0030);
        tick();
        rd_chk("ti_set", 8'h68, 32'hc000_8030);
        rd_chk("ti_count", 8'h48, 32'd3);
        chk("ti_no_int", {31'd0, Int_Pending}, 32'd0);

        // ---- enable timer interrupt, then take it over a coincident MTC0 ----
        mtc0("mtc0_st_fl", 8'h60, 32'h0040_8001);
        rd_chk("int_status", 8'h60, 32'h0040_8001);
        chk("int_pend", {31'd0, Int_Pending}, 32'd1);
        MEM_Valid   = 1'b1;
        MEM_CP0WrEn = 1'b1;
        MEM_CP0Rd   = 1'b1;
        MEM_CP0Addr = 8'h60;
        MEM_GPR_RT  = 32'd0;
        MEM_PC      = 32'h0000_2000;
        #1;
        chk("int_flush", {31'd0, Exc_Flush}, 32'd1);
        chk("int_pc", Exc_PC, VEC);
        chk("int_pre_rd", CP0Out, 32'h0040_8001);
        tick();
        idle_in();
        rd_chk("int_status2", 8'h60, 32'h0040_8003);
        rd_chk("int_cause", 8'h68, 32'h4000_8000);
        chk("int_epc", EPC_Out, 32'h0000_2000);
        chk("int_pend_exl", {31'd0, Int_Pending}, 32'd0);

        // ---- Compare write clears TI ----
        mtc0("mtc0_cmp_fl2", 8'h58, 32'hffff_ffff);
        rd_chk("ti_clear", 8'h68, 32'h0000_0000);

        // ---- nested syscall-like exception, then ERET back to 0x2000 ----
        exc_step(5'd8, 32'h0000_5000, 1'b0, 32'd0);
        tick();
        idle_in();
        rd_chk("sys_cause", 8'h68, 32'h0000_0020);
        MEM_Valid      = 1'b1;
        MEM_eret_flush = 1'b1;
        #1;
        chk("eret2_pc", Exc_PC, 32'h0000_2000);
        tick();
        idle_in();
        rd_chk("eret2_status", 8'h60, 32'h0040_8001);

        // ---- interrupt that drops before a valid instruction is not taken ----
        ext_int = 6'b10_0000;
        #1;
        chk("drop_pend", {31'd0, Int_Pending}, 32'd1);
        tick();
        ext_int   = 6'd0;
        MEM_Valid = 1'b1;
        #1;
        chk("drop_noflush", {31'd0, Exc_Flush}, 32'd0);
        tick();
        idle_in();

        // ---- exception and interrupt together: interrupt wins, code 0 ----
        ext_int = 6'b10_0000;
        exc_step(5'd10, 32'h0000_3000, 1'b1, 32'd0);
        chk("both_flush", {31'd0, Exc_Flush}, 32'd1);
        chk("both_pc", Exc_PC, VEC);
        tick();
        idle_in();
        ext_int = 6'd0;
        #1;
        rd_chk("both_cause", 8'h68, 32'h8000_0000);
        chk("both_epc", EPC_Out, 32'h0000_2ffc);
        rd_chk("both_status", 8'h60, 32'h0040_8003);

        // ---- writable masks and unmapped address ----
        mtc0("mtc0_stm_fl", 8'h60, 32'hffff_ffff);
        rd_chk("mask_status", 8'h60, 32'h0040_ff03);
        mtc0("mtc0_cam_fl", 8'h68, 32'hffff_ffff);
        rd_chk("mask_cause", 8'h68, 32'h8000_0300);
        mtc0("mtc0_unm_fl", 8'h08, 32'hffff_ffff);
        rd_chk("unmapped_rd", 8'h08, 32'd0);

        // ---- reset pulse in the middle of an AdEL commit ----
        exc_step(5'd4, 32'h0000_4000, 1'b0, 32'hdead_beef);
        chk("mid_flush", {31'd0, Exc_Flush}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("mid_rst_pc", Exc_PC, VEC);
        @(posedge clk);
        #2;
        idle_in();
        rst = 1'b1;
        rd_chk("mid_status", 8'h60, 32'h0040_0000);
        rd_chk("mid_cause", 8'h68, 32'd0);
        rd_chk("mid_epc", 8'h70, 32'd0);
        rd_chk("mid_bva", 8'h40, 32'd0);
        rd_chk("mid_count", 8'h48, 32'd0);
        rd_chk("mid_compare", 8'h58, 32'd0);
        chk("mid_epc_out", EPC_Out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 register file and exception/ERET commit unit. Consumes the exception, branch-delay, ERET and MTC0/MFC0 fields that the EX/MEM pipeline register delivers to the MEM stage. It commits precise exceptions and interrupts, updates BadVAddr/Count/Compare/Status/Cause/EPC, and returns the pipeline-wide flush and redirect PC to the flip-flop stages and the PC register.

## Interface
- EXC_VECTOR, 32'hbfc0_0380, exception entry PC
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ext_int  in  6  hardware interrupt lines, level, synchronous to clk
- MEM_Valid  in  1  MEM stage holds a real instruction (not a bubble)
- MEM_Exception  in  1  exception flagged for MEM instruction
- MEM_ExcCode  in  5  exception code
- MEM_isBD  in  1  MEM instruction sits in a delay slot
- MEM_PC  in  32  MEM instruction PC
- badvaddr  in  32  faulting address
- MEM_eret_flush  in  1  MEM instruction is ERET
- MEM_CP0WrEn  in  1  MTC0 in MEM
- MEM_CP0Rd  in  1  MFC0 in MEM
- MEM_CP0Addr  in  8  {rd[4:0], sel[2:0]}
- MEM_GPR_RT  in  32  MTC0 write data
- CP0Out  out  32  MFC0 read data (combinational)
- Exc_Flush  out  1  flush IF/ID/EX/MEM and PC (combinational)
- Exc_PC  out  32  redirect target, valid when Exc_Flush=1
- EPC_Out  out  32  current EPC
- Int_Pending  out  1  an enabled interrupt is pending

## Operation
- Addresses: BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70. Any other address reads 0 and ignores writes.
- Status: only IM[15:8], EXL[1] and IE[0] are writable. BEV[22] is hard 1. All other bits read 0.
- Cause:
  - BD[31] and TI[30] are read-only.
  - IP[15:10] = {ext_int[5]|TI, ext_int[4:0]}, sampled live.
  - IP[9:8] are writable.
  - ExcCode[6:2] is read-only.
- Int_Pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- Commit events, evaluated only when MEM_Valid=1. Priority, highest first:
  1. Interrupt: Int_Pending. Code 0.
  2. Exception: MEM_Exception. Code MEM_ExcCode.
  3. ERET: MEM_eret_flush.
  4. MTC0: MEM_CP0WrEn.
- A higher-priority event suppresses all lower ones for that instruction. An interrupt or exception kills a coincident MTC0/ERET.
- Interrupt/exception commit:
  - Exc_Flush=1, Exc_PC=EXC_VECTOR.
  - At the edge: Cause.ExcCode←code, Status.EXL←1.
  - If old EXL=0: EPC←(MEM_isBD ? MEM_PC-4 : MEM_PC) and Cause.BD←MEM_isBD.
  - If old EXL=1: EPC and BD are unchanged.
  - If code is AdEL(4) or AdES(5): BadVAddr←badvaddr.
- ERET commit:
  - Exc_Flush=1, Exc_PC=EPC (current register value).
  - At the edge: Status.EXL←0.
- MTC0 write: at the edge, the addressed register takes MEM_GPR_RT through its writable mask.
- Count:
  - A tick flop toggles every cycle. Count increments (mod 2^32) on edges where tick=1.
  - An MTC0 to Count overrides the increment that edge and clears tick.
- TI:
  - Set on any edge where Count==Compare and Compare is not being written.
  - Sticky.
  - Cleared by an MTC0 to Compare; the clear wins over a coincident set.
- CP0Out = MEM_CP0Rd ? register[MEM_CP0Addr] : 0. Reads return the pre-edge value, including when a same-cycle write is suppressed.

## Timing
- Reset (async, rst=0):
  - BadVAddr, Count, Compare, Cause, EPC and the tick flop = 0.
  - Status = STATUS_RST.
  - Outputs: CP0Out=0, Exc_Flush=0, Int_Pending=0, EPC_Out=0, Exc_PC=EXC_VECTOR.
  - Reset asserted mid-commit aborts the update; no partial register state remains.
- Exc_Flush and Exc_PC are combinational in the commit cycle. Register updates land at the following rising edge. Latency from MEM entry to redirect is 0 cycles.
- Exc_Flush is a single-cycle pulse per committing instruction. The flushed bubble arrives with MEM_Valid=0, so no double commit occurs.
- MTC0 EPC immediately followed by ERET: the write lands at the edge before the ERET reaches MEM, so Exc_PC returns the new value.
- ext_int is sampled every cycle; there is no latching. An interrupt that drops before a valid MEM instruction is not taken.

## Test plan
- Reset then 10 idle cycles with MEM_Valid=0 → Status=32'h0040_0000, Count=5, Exc_Flush never 1.
- MEM_Exception=1, ExcCode=5 (AdES), MEM_PC=32'hbfc0_1004, isBD=1, badvaddr=32'h8000_0003 → Exc_Flush=1 and Exc_PC=32'hbfc0_0380 that cycle; next cycle EPC=32'hbfc0_1000, Cause=32'h8000_0014, BadVAddr=32'h8000_0003, Status.EXL=1.
- With EXL=1, exception code 12 at MEM_PC=32'h1234 → EPC unchanged, Cause.ExcCode=12, Exc_Flush=1.
- MTC0 EPC←32'hbfc0_2000, then ERET next cycle → Exc_PC=32'hbfc0_2000 and EXL cleared.
- MTC0 Compare←3, then idle → TI=1 once Count==3; Status=32'h0040_8001 with valid MEM instruction → interrupt commit, Cause.ExcCode=0, coincident MTC0 Status ignored; MTC0 Compare clears TI.
- Exception and interrupt in the same cycle → ExcCode=0. rst pulse low mid-commit → all registers at reset values on release.
